// File: rtl/triangle_rasterizer.sv
// Flat-shaded triangle scan converter: bounding-box walk with incremental edge functions, one pixel per clock.
// Define RASTER_BACKFACE_CULL_EN to drop clockwise (negative-area) triangles during setup.
module triangle_rasterizer #(
  parameter int DISPLAY_WIDTH       = 160,
  parameter int DISPLAY_HEIGHT      = 120,
  parameter int DISPLAY_COORD_WIDTH = 16,
  parameter int FB_DATA_WIDTH       = 4,
  parameter int DB_DATA_WIDTH       = 12,
  localparam int BUFFER_ADDR_WIDTH  = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  display_ready,
  input  logic signed [DISPLAY_COORD_WIDTH-1:0] x0,
  input  logic signed [DISPLAY_COORD_WIDTH-1:0] y0,
  input  logic signed [DISPLAY_COORD_WIDTH-1:0] x1,
  input  logic signed [DISPLAY_COORD_WIDTH-1:0] y1,
  input  logic signed [DISPLAY_COORD_WIDTH-1:0] x2,
  input  logic signed [DISPLAY_COORD_WIDTH-1:0] y2,
  input  logic [FB_DATA_WIDTH-1:0]              i_color,
  input  logic [DB_DATA_WIDTH-1:0]              i_depth,
  output logic                                  o_ready,
  output logic                                  o_done,
  output logic [BUFFER_ADDR_WIDTH-1:0]          buffer_addr_write,
  output logic [FB_DATA_WIDTH-1:0]              o_fb_data,
  output logic [DB_DATA_WIDTH-1:0]              o_db_data,
  output logic                                  addr_inside_triangle
);
  localparam int CW = DISPLAY_COORD_WIDTH;
  localparam int EW = 2 * CW + 2;
  localparam int XW = $clog2(DISPLAY_WIDTH);
  localparam int YW = $clog2(DISPLAY_HEIGHT);
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam logic signed [CW-1:0] X_LAST = CW'(DISPLAY_WIDTH - 1);
  localparam logic signed [CW-1:0] Y_LAST = CW'(DISPLAY_HEIGHT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_INIT, S_RASTER, S_DONE} state_t;
  state_t state_reg, state_next;

  logic signed [CW-1:0]     vx_reg [3];
  logic signed [CW-1:0]     vy_reg [3];
  logic [FB_DATA_WIDTH-1:0] color_reg;
  logic [DB_DATA_WIDTH-1:0] depth_reg;
  logic [XW-1:0]            xmin_reg, xmax_reg, x_reg;
  logic [YW-1:0]            ymin_reg, ymax_reg, y_reg;
  logic                     area_neg_reg;
  logic signed [EW-1:0]     e_row_reg [3];
  logic signed [EW-1:0]     e_cur_reg [3];
  logic [AW-1:0]            addr_reg;
  logic                     inside_reg, done_reg;

  logic signed [EW-1:0] vxe [3];
  logic signed [EW-1:0] vye [3];
  logic signed [EW-1:0] edge_dx [3];
  logic signed [EW-1:0] edge_dy [3];
  logic signed [EW-1:0] e_init [3];
  logic signed [EW-1:0] xmin_e, ymin_e, area;
  logic signed [CW-1:0] min_x, max_x, min_y, max_y;
  logic [2:0]           ge0, le0;
  logic                 box_empty, cull, last_pixel, pixel_inside;
  logic [AW-1:0]        pixel_addr;

  function automatic logic [XW-1:0] clamp_x(input logic signed [CW-1:0] v);
    if (v[CW-1]) return '0;
    if (v > X_LAST) return XW'(DISPLAY_WIDTH - 1);
    return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic signed [CW-1:0] v);
    if (v[CW-1]) return '0;
    if (v > Y_LAST) return YW'(DISPLAY_HEIGHT - 1);
    return v[YW-1:0];
  endfunction

  assign xmin_e = {{(EW-XW){1'b0}}, xmin_reg};
  assign ymin_e = {{(EW-YW){1'b0}}, ymin_reg};

  // Edge i runs from vertex i to vertex (i+1)%3; dx is the row step, dy the per-pixel decrement.
  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    localparam int B = (gi + 1) % 3;
    assign vxe[gi]     = {{(EW-CW){vx_reg[gi][CW-1]}}, vx_reg[gi]};
    assign vye[gi]     = {{(EW-CW){vy_reg[gi][CW-1]}}, vy_reg[gi]};
    assign edge_dx[gi] = vxe[B] - vxe[gi];
    assign edge_dy[gi] = vye[B] - vye[gi];
    assign e_init[gi]  = edge_dx[gi] * (ymin_e - vye[gi]) - edge_dy[gi] * (xmin_e - vxe[gi]);
    assign ge0[gi]     = ~e_cur_reg[gi][EW-1];
    assign le0[gi]     = e_cur_reg[gi][EW-1] | (e_cur_reg[gi] == '0);
  end

  assign area = edge_dx[0] * (vye[2] - vye[0]) - edge_dy[0] * (vxe[2] - vxe[0]);

  always_comb begin
    min_x = vx_reg[0];
    max_x = vx_reg[0];
    min_y = vy_reg[0];
    max_y = vy_reg[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_reg[i] < min_x) min_x = vx_reg[i];
      if (vx_reg[i] > max_x) max_x = vx_reg[i];
      if (vy_reg[i] < min_y) min_y = vy_reg[i];
      if (vy_reg[i] > max_y) max_y = vy_reg[i];
    end
  end

  assign box_empty = max_x[CW-1] | max_y[CW-1] | (min_x > X_LAST) | (min_y > Y_LAST);

`ifdef RASTER_BACKFACE_CULL_EN
  assign cull = area[EW-1];
`else
  assign cull = 1'b0;
`endif

  assign last_pixel   = (x_reg == xmax_reg) && (y_reg == ymax_reg);
  assign pixel_inside = area_neg_reg ? (&le0) : (&ge0);
  assign pixel_addr   = AW'(y_reg) * AW'(DISPLAY_WIDTH) + AW'(x_reg);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        o_ready = 1'b1;
        if (start) state_next = S_SETUP;
      end
      S_SETUP:  state_next = ((area == '0) || box_empty || cull) ? S_DONE : S_INIT;
      S_INIT:   state_next = S_RASTER;
      S_RASTER: if (display_ready && last_pixel) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        vx_reg[i]    <= '0;
        vy_reg[i]    <= '0;
        e_row_reg[i] <= '0;
        e_cur_reg[i] <= '0;
      end
      color_reg    <= '0;
      depth_reg    <= '0;
      xmin_reg     <= '0;
      xmax_reg     <= '0;
      ymin_reg     <= '0;
      ymax_reg     <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      area_neg_reg <= 1'b0;
      addr_reg     <= '0;
      inside_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      inside_reg <= 1'b0;
      done_reg   <= (state_reg == S_DONE);
      case (state_reg)
        S_IDLE: if (start) begin
          vx_reg[0] <= x0; vy_reg[0] <= y0;
          vx_reg[1] <= x1; vy_reg[1] <= y1;
          vx_reg[2] <= x2; vy_reg[2] <= y2;
          color_reg <= i_color;
          depth_reg <= i_depth;
        end
        S_SETUP: begin
          xmin_reg     <= clamp_x(min_x);
          xmax_reg     <= clamp_x(max_x);
          ymin_reg     <= clamp_y(min_y);
          ymax_reg     <= clamp_y(max_y);
          area_neg_reg <= area[EW-1];
        end
        S_INIT: begin
          x_reg <= xmin_reg;
          y_reg <= ymin_reg;
          for (int i = 0; i < 3; i++) begin
            e_row_reg[i] <= e_init[i];
            e_cur_reg[i] <= e_init[i];
          end
        end
        S_RASTER: if (display_ready) begin
          inside_reg <= pixel_inside;
          addr_reg   <= pixel_addr;
          if (x_reg == xmax_reg) begin
            x_reg <= xmin_reg;
            y_reg <= y_reg + 1'b1;
            for (int i = 0; i < 3; i++) begin
              e_row_reg[i] <= e_row_reg[i] + edge_dx[i];
              e_cur_reg[i] <= e_row_reg[i] + edge_dx[i];
            end
          end else begin
            x_reg <= x_reg + 1'b1;
            for (int i = 0; i < 3; i++) e_cur_reg[i] <= e_cur_reg[i] - edge_dy[i];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_done               = done_reg;
  assign addr_inside_triangle = inside_reg;
  assign buffer_addr_write    = addr_reg;
  assign o_fb_data            = color_reg;
  assign o_db_data            = depth_reg;
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Scoreboard bench for triangle_rasterizer: the driver queues expected writes and completion timing,
// an independent monitor pops and compares every write enable and o_done pulse.
module tb_triangle_rasterizer;
  localparam int W   = 160;
  localparam int CW  = 16;
  localparam int FBW = 4;
  localparam int DBW = 12;
  localparam int AW  = 15;

  logic clk = 1'b0;
  logic rst, start, display_ready;
  logic signed [CW-1:0] x0, y0, x1, y1, x2, y2;
  logic [FBW-1:0] i_color;
  logic [DBW-1:0] i_depth;
  logic o_ready, o_done, addr_inside_triangle;
  logic [AW-1:0] buffer_addr_write;
  logic [FBW-1:0] o_fb_data;
  logic [DBW-1:0] o_db_data;

  triangle_rasterizer dut (
    .clk(clk), .rst(rst), .start(start), .display_ready(display_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .i_color(i_color), .i_depth(i_depth),
    .o_ready(o_ready), .o_done(o_done), .buffer_addr_write(buffer_addr_write),
    .o_fb_data(o_fb_data), .o_db_data(o_db_data),
    .addr_inside_triangle(addr_inside_triangle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           t_start;
    int           done_lat;
    int           first_lat;
    logic [FBW-1:0] color;
    logic [DBW-1:0] depth;
  } tri_t;

  tri_t tri_q[$];
  int   exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_seen = -1;
  logic stalled_prev = 1'b0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    stalled_prev <= !display_ready;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Monitor: consumes the scoreboard queues whenever the DUT presents a write or a done pulse.
  always @(negedge clk) begin : mon
    int   e;
    tri_t t;
    if (stalled_prev) check("stall_we", {31'd0, addr_inside_triangle}, 32'd0);
    if (addr_inside_triangle === 1'b1) begin
      if (exp_q.size() == 0 || tri_q.size() == 0) begin
        check("unexpected_write", {17'd0, buffer_addr_write}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("addr", {17'd0, buffer_addr_write}, e);
        check("fb_data", {28'd0, o_fb_data}, {28'd0, tri_q[0].color});
        check("db_data", {20'd0, o_db_data}, {20'd0, tri_q[0].depth});
        if (first_seen < 0) first_seen = cyc - tri_q[0].t_start;
      end
    end
    if (o_done === 1'b1) begin
      if (tri_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        t = tri_q.pop_front();
        check("done_latency", cyc - t.t_start, t.done_lat);
        check("writes_missing", exp_q.size(), 0);
        if (t.first_lat >= 0) check("first_pixel_latency", first_seen, t.first_lat);
        else                  check("no_writes", first_seen, -1);
        $display("triangle complete: latency %0d cycles, first write at %0d", cyc - t.t_start, first_seen);
        exp_q.delete();
        first_seen = -1;
      end
    end
  end

  task automatic push_t1();
    int a[10] = '{0, 1, 2, 3, 160, 161, 162, 320, 321, 480};
    foreach (a[i]) exp_q.push_back(a[i]);
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int col, input int dep,
                         input int done_lat, input int first_lat,
                         input int stall_at, input int stall_len, input int abort_at);
    tri_t t;
    bit   seen = 1'b0;
    int   n_done;
    @(negedge clk);
    check("ready_before_start", {31'd0, o_ready}, 32'd1);
    x0 = CW'(ax); y0 = CW'(ay); x1 = CW'(bx); y1 = CW'(by); x2 = CW'(cx); y2 = CW'(cy);
    i_color = FBW'(col);
    i_depth = DBW'(dep);
    t.t_start   = cyc;
    t.done_lat  = done_lat;
    t.first_lat = first_lat;
    t.color     = FBW'(col);
    t.depth     = DBW'(dep);
    tri_q.push_back(t);
    start = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        tri_q.delete();
        exp_q.delete();
        first_seen = -1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_we", {31'd0, addr_inside_triangle}, 32'd0);
        check("abort_ready", {31'd0, o_ready}, 32'd1);
        n_done = 0;
        repeat (30) begin
          @(negedge clk);
          if (o_done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);
        return;
      end
      if (k == stall_at) display_ready = 1'b0;
      if (k == stall_at + stall_len) display_ready = 1'b1;
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      tri_q.delete();
      exp_q.delete();
    end else begin
      @(negedge clk);
      check("done_single_pulse", {31'd0, o_done}, 32'd0);
      check("ready_after_done", {31'd0, o_ready}, 32'd1);
      check("hold_fb", {28'd0, o_fb_data}, col);
      check("hold_db", {20'd0, o_db_data}, dep);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; display_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    i_color = '0; i_depth = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_we", {31'd0, addr_inside_triangle}, 32'd0);
    check("rst_addr", {17'd0, buffer_addr_write}, 32'd0);
    check("rst_fb", {28'd0, o_fb_data}, 32'd0);
    check("rst_db", {20'd0, o_db_data}, 32'd0);
    rst = 1'b0;

    // Counter-clockwise right triangle: 16 scan cycles, 10 writes.
    push_t1();
    run_tri(0, 0, 3, 0, 0, 3, 5, 'h100, 20, 4, 0, 0, 0);

    // Same triangle, opposite winding.
`ifdef RASTER_BACKFACE_CULL_EN
    run_tri(0, 0, 0, 3, 3, 0, 9, 'h2AB, 3, -1, 0, 0, 0);
`else
    push_t1();
    run_tri(0, 0, 0, 3, 3, 0, 9, 'h2AB, 20, 4, 0, 0, 0);
`endif

    // Fully off-screen and zero-area triangles complete without writes.
    run_tri(-10, -10, -5, -10, -10, -5, 3, 'h0FF, 3, -1, 0, 0, 0);
    run_tri(2, 2, 4, 4, 6, 6, 7, 'h555, 3, -1, 0, 0, 0);

    // Bounding box clamped to the bottom-right corner; every box pixel lies inside.
    for (int yy = 110; yy <= 119; yy++)
      for (int xx = 150; xx <= 159; xx++) exp_q.push_back(yy * W + xx);
    run_tri(150, 110, 200, 110, 150, 200, 12, 'hABC, 104, 4, 0, 0, 0);

    // Five-cycle display stall in the middle of the scan.
    push_t1();
    run_tri(0, 0, 3, 0, 0, 3, 5, 'h100, 25, 4, 8, 5, 0);

    // Reset during RASTER, then a normal triangle.
    push_t1();
    run_tri(0, 0, 3, 0, 0, 3, 6, 'h0AA, 20, 4, 0, 0, 8);
    push_t1();
    run_tri(0, 0, 3, 0, 0, 3, 5, 'h100, 20, 4, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queues_drained", tri_q.size() + exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
